wave_synth_dds: RTL

WAVE_SYNTH_DDS -- requirements
Module: wave_synth_dds

---
 rtl/wave_synth_dds.sv | 116 +++++++++++
 1 files changed

// File: rtl/wave_synth_dds.sv
// Phase-accumulator waveform synthesiser (sine via external BRAM, square, triangle, sawtooth).
// Optional output amplitude scaling stage is enabled by defining WAVE_AMP_SCALE_EN.
module wave_synth_dds #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned SIN_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [DATA_W-1:0]  duty,
  input  logic [DATA_W-1:0]  amp,
  output logic [SIN_AW-1:0]  sin_addr,
  input  logic [DATA_W-1:0]  sin_data,
  output logic [DATA_W-1:0]  wave_out,
  output logic               out_valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    M_SINE   = 2'b00,
    M_SQUARE = 2'b01,
    M_TRI    = 2'b10,
    M_SAW    = 2'b11
  } mode_e;

  localparam int unsigned TOP = PHASE_W - 1;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               carry;
  logic               step_wrap;
  logic               wrap_q;
  mode_e              pend_q, act_q, m1_q;
  logic [DATA_W-1:0]  p1_q;
  logic               sq1_q, v1_q;
  logic [DATA_W-1:0]  wave_q, wave_d;
  logic               v2_q;
  logic [DATA_W-1:0]  tri_q;

  assign {carry, phase_d} = {1'b0, phase_q} + {1'b0, ftw};
  assign step_wrap        = en & carry;

  // The square comparison is resolved in stage 1 so a new duty applies to the very next step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      wrap_q  <= 1'b0;
      pend_q  <= M_SINE;
      act_q   <= M_SINE;
      p1_q    <= '0;
      m1_q    <= M_SINE;
      sq1_q   <= 1'b0;
      v1_q    <= 1'b0;
      wave_q  <= '0;
      v2_q    <= 1'b0;
    end else begin
      wrap_q <= step_wrap;
      if (en) phase_q <= phase_d;
      pend_q <= mode_e'(sel);
      if (!en || step_wrap) act_q <= pend_q;
      v1_q <= en;
      if (en) begin
        p1_q  <= phase_q[TOP -: DATA_W];
        m1_q  <= act_q;
        sq1_q <= (phase_q[TOP -: DATA_W] < duty);
      end
      v2_q <= v1_q;
      if (v1_q) wave_q <= wave_d;
    end
  end

  assign tri_q = {p1_q[DATA_W-2:0], 1'b0};

  always_comb begin
    wave_d = '0;
    case (m1_q)
      M_SINE:   wave_d = sin_data;
      M_SQUARE: wave_d = sq1_q ? '1 : '0;
      M_TRI:    wave_d = p1_q[DATA_W-1] ? ~tri_q : tri_q;
      M_SAW:    wave_d = p1_q;
      default:  wave_d = '0;
    endcase
  end

  assign sin_addr = phase_q[TOP -: SIN_AW];
  assign wrap     = wrap_q;

`ifdef WAVE_AMP_SCALE_EN
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   wave3_q;
  logic                v3_q;

  assign prod = {{DATA_W{1'b0}}, wave_q} * {{DATA_W{1'b0}}, amp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave3_q <= '0;
      v3_q    <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) wave3_q <= prod[2*DATA_W-1 -: DATA_W];
    end
  end

  assign wave_out  = wave3_q;
  assign out_valid = v3_q;
`else
  logic unused_amp;
  assign unused_amp = ^amp;
  assign wave_out   = wave_q;
  assign out_valid  = v2_q;
`endif

endmodule
